// File: rtl/nh_lcd_frame_scheduler.sv
// nh_lcd_frame_scheduler
// Arbitrates a single 8-bit LCD write bus between a one-deep command holding
// register and a TE-synchronised pixel writer, with frame accounting.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | bus free; a held command wins, else arm a frame
// CMD       | held command byte is on the bus for this one cycle
// CMD_GAP   | bus kept quiet for CMD_GAP_CYCLES after a command byte
// WAIT_TE   | frame armed, waiting for a TE rising edge
// FRAME     | pixel writer owns the bus, bytes forwarded with 1-cycle latency
// FRAME_END | one settle cycle after a completed or aborted frame
module nh_lcd_frame_scheduler #(
  parameter int CMD_GAP_CYCLES = 2,
  parameter int TIMEOUT_CYCLES = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_enable,
  input  logic [31:0] i_num_pixels,
  input  logic        i_cmd_stb,
  input  logic        i_cmd_mode,
  input  logic [7:0]  i_cmd_data,
  output logic        o_cmd_busy,
  output logic        o_pix_enable,
  input  logic        i_pix_write,
  input  logic        i_pix_cmd_mode,
  input  logic [7:0]  i_pix_data,
  input  logic        i_tearing_effect,
  output logic        o_data_cmd_mode,
  output logic [7:0]  o_data,
  output logic        o_write,
  output logic        o_frame_done,
  output logic        o_frame_abort,
  output logic        o_underrun,
  output logic [31:0] o_frame_count
);

  // Gap timer is a down-counter loaded in CMD; a zero gap still costs one cycle.
  localparam logic [15:0] GAP_LOAD = (CMD_GAP_CYCLES > 1) ? 16'(CMD_GAP_CYCLES - 1) : 16'd0;
  // Timeout fires when the idle count would reach TIMEOUT_CYCLES.
  localparam logic [15:0] TO_LAST  = (TIMEOUT_CYCLES > 1) ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    CMD_GAP,
    WAIT_TE,
    FRAME,
    FRAME_END
  } state_t;

  state_t      state_q, state_d;
  logic        cmd_pending_q, cmd_pending_d;
  logic        cmd_mode_q;
  logic [7:0]  cmd_data_q;
  logic        cmd_accept;
  logic [15:0] gap_cnt_q, gap_cnt_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] pix_cnt_q, pix_cnt_d;
  logic [31:0] num_pix_q, num_pix_d;
  logic [15:0] to_cnt_q, to_cnt_d;
  logic        te_prev_q;
  logic        pix_en_d;
  logic        pix_inc;
  logic        wr_d;
  logic [7:0]  data_d;
  logic        mode_d;
  logic        done_d;
  logic        abort_d;
  logic        underrun_d;

  assign cmd_accept = i_cmd_stb && !cmd_pending_q;
  assign o_cmd_busy = cmd_pending_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, counter and bus-output decode; bus fields hold when not written.
  always_comb begin
    state_d       = state_q;
    cmd_pending_d = cmd_pending_q;
    gap_cnt_d     = gap_cnt_q;
    byte_cnt_d    = byte_cnt_q;
    pix_cnt_d     = pix_cnt_q;
    num_pix_d     = num_pix_q;
    to_cnt_d      = to_cnt_q;
    pix_en_d      = o_pix_enable;
    pix_inc       = 1'b0;
    wr_d          = 1'b0;
    data_d        = o_data;
    mode_d        = o_data_cmd_mode;
    done_d        = 1'b0;
    abort_d       = 1'b0;
    underrun_d    = 1'b0;

    if (cmd_accept) begin
      cmd_pending_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (cmd_pending_q) begin
          // Bus strobe is registered so it coincides with the CMD state cycle.
          state_d = CMD;
          wr_d    = 1'b1;
          data_d  = cmd_data_q;
          mode_d  = cmd_mode_q;
        end else if (i_enable && (i_num_pixels != 32'd0)) begin
          state_d = WAIT_TE;
        end
      end
      CMD: begin
        state_d   = CMD_GAP;
        gap_cnt_d = GAP_LOAD;
      end
      CMD_GAP: begin
        if (gap_cnt_q == 16'd0) begin
          state_d       = IDLE;
          cmd_pending_d = 1'b0;
        end else begin
          gap_cnt_d = gap_cnt_q - 16'd1;
        end
      end
      WAIT_TE: begin
        // A zero pixel count is never started, even if it changes while armed.
        if (!i_enable || (i_num_pixels == 32'd0)) begin
          state_d = IDLE;
        end else if (i_tearing_effect && !te_prev_q) begin
          state_d    = FRAME;
          byte_cnt_d = 2'd0;
          pix_cnt_d  = 32'd0;
          to_cnt_d   = 16'd0;
          num_pix_d  = i_num_pixels;
          pix_en_d   = 1'b1;
        end
      end
      FRAME: begin
        if (i_pix_write) begin
          wr_d     = 1'b1;
          data_d   = i_pix_data;
          mode_d   = i_pix_cmd_mode;
          to_cnt_d = 16'd0;
          if (!i_pix_cmd_mode) begin
            if (byte_cnt_q == 2'd2) begin
              byte_cnt_d = 2'd0;
              pix_cnt_d  = pix_cnt_q + 32'd1;
              pix_inc    = 1'b1;
            end else begin
              byte_cnt_d = byte_cnt_q + 2'd1;
            end
          end
        end else if (to_cnt_q == TO_LAST) begin
          to_cnt_d   = 16'd0;
          underrun_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 16'd1;
        end
        // Compare against the incremented count so the writer is stopped
        // before it can present a byte beyond the frame.
        if (pix_inc && (pix_cnt_d == num_pix_q)) begin
          state_d  = FRAME_END;
          pix_en_d = 1'b0;
          done_d   = 1'b1;
        end else if (!i_enable && (byte_cnt_d == 2'd0)) begin
          state_d    = FRAME_END;
          pix_en_d   = 1'b0;
          abort_d    = 1'b1;
          underrun_d = 1'b0;
        end
      end
      FRAME_END: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath registers, command holding register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_pending_q   <= 1'b0;
      cmd_mode_q      <= 1'b0;
      cmd_data_q      <= 8'd0;
      gap_cnt_q       <= 16'd0;
      byte_cnt_q      <= 2'd0;
      pix_cnt_q       <= 32'd0;
      num_pix_q       <= 32'd0;
      to_cnt_q        <= 16'd0;
      te_prev_q       <= 1'b0;
      o_pix_enable    <= 1'b0;
      o_write         <= 1'b0;
      o_data          <= 8'd0;
      o_data_cmd_mode <= 1'b0;
      o_frame_done    <= 1'b0;
      o_frame_abort   <= 1'b0;
      o_underrun      <= 1'b0;
      o_frame_count   <= 32'd0;
    end else begin
      cmd_pending_q   <= cmd_pending_d;
      if (cmd_accept) begin
        cmd_mode_q <= i_cmd_mode;
        cmd_data_q <= i_cmd_data;
      end
      gap_cnt_q       <= gap_cnt_d;
      byte_cnt_q      <= byte_cnt_d;
      pix_cnt_q       <= pix_cnt_d;
      num_pix_q       <= num_pix_d;
      to_cnt_q        <= to_cnt_d;
      te_prev_q       <= i_tearing_effect;
      o_pix_enable    <= pix_en_d;
      o_write         <= wr_d;
      o_data          <= data_d;
      o_data_cmd_mode <= mode_d;
      o_frame_done    <= done_d;
      o_frame_abort   <= abort_d;
      o_underrun      <= underrun_d;
      if (done_d) begin
        o_frame_count <= o_frame_count + 32'd1;
      end
    end
  end

endmodule
